// File: rtl/regs_wport_arbiter.sv
// Write-port controller for an 8x32 register file: round-robin sharing of
// the single write port between two requesters, plus a whole-file fill.
module regs_wport_arbiter #(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          cr,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] data0,
   output logic          ack0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] data1,
   output logic          ack1,
   input  logic          fill_start,
   input  logic [DW-1:0] fill_val,
   output logic          fill_busy,
   output logic          fill_done,
   output logic          WE,
   output logic [AW-1:0] Addr_W,
   output logic [DW-1:0] Di
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);
   localparam logic [AW-1:0] CNT1   = AW'((NREG > 1) ? 1 : 0);

   state_t        state_q;
   logic [AW-1:0] cnt_q;
   logic          last_q;
   logic [DW-1:0] fval_q;

   // Address 0 is written on the start edge itself, so the counter
   // already points at the second address when FILL is entered.
   always_ff @(posedge clk or posedge cr) begin
      if (cr) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         fval_q    <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
         WE        <= 1'b0;
         Addr_W    <= '0;
         Di        <= '0;
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         fill_done <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (fill_start) begin
                  state_q   <= S_FILL;
                  fval_q    <= fill_val;
                  cnt_q     <= CNT1;
                  fill_busy <= 1'b1;
                  WE        <= 1'b1;
                  Addr_W    <= '0;
                  Di        <= fill_val;
               end else if (req0 && (!req1 || last_q)) begin
                  WE     <= 1'b1;
                  Addr_W <= addr0;
                  Di     <= data0;
                  ack0   <= 1'b1;
                  last_q <= 1'b0;
               end else if (req1) begin
                  WE     <= 1'b1;
                  Addr_W <= addr1;
                  Di     <= data1;
                  ack1   <= 1'b1;
                  last_q <= 1'b1;
               end else begin
                  WE <= 1'b0;
               end
            end
            S_FILL: begin
               if (Addr_W == LAST_A) begin
                  state_q   <= S_IDLE;
                  cnt_q     <= '0;
                  fill_busy <= 1'b0;
                  fill_done <= 1'b1;
                  WE        <= 1'b0;
               end else begin
                  WE     <= 1'b1;
                  Addr_W <= cnt_q;
                  Di     <= fval_q;
                  if (cnt_q != LAST_A) cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regs_wport_arbiter.sv
// Bench for regs_wport_arbiter: vector table, fill/reset sequences and
// random traffic against a cycle-level behavioural model.
module tb_regs_wport_arbiter;

   localparam int NREG = 8;
   localparam int AW   = 3;
   localparam int DW   = 32;

   logic          clk = 1'b0;
   logic          cr  = 1'b1;
   logic          req0 = 0, req1 = 0, fill_start = 0;
   logic [AW-1:0] addr0 = 0, addr1 = 0;
   logic [DW-1:0] data0 = 0, data1 = 0, fill_val = 0;
   logic          ack0, ack1, fill_busy, fill_done, WE;
   logic [AW-1:0] Addr_W;
   logic [DW-1:0] Di;

   int checks = 0;
   int failures = 0;

   regs_wport_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
      .clk(clk), .cr(cr),
      .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
      .fill_start(fill_start), .fill_val(fill_val),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .WE(WE), .Addr_W(Addr_W), .Di(Di)
   );

   always #5 clk = ~clk;

   // Register file behind the write port
   logic [DW-1:0] mem [NREG];
   always @(posedge clk or posedge cr) begin
      if (cr) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (WE) begin
         mem[Addr_W] <= Di;
      end
   end

   // Behavioural model: a fill is "NREG writes of one value, then a done
   // cycle"; otherwise round robin over whoever is asking.
   logic          m_we, m_ack0, m_ack1, m_busy, m_done;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_di, m_fv;
   int            m_last, m_left, m_pos;
   bit            m_in_fill;

   task automatic model_reset();
      m_we = 0; m_ack0 = 0; m_ack1 = 0; m_busy = 0; m_done = 0;
      m_addr = 0; m_di = 0; m_fv = 0;
      m_last = 1; m_left = 0; m_pos = 0; m_in_fill = 0;
   endtask

   task automatic model_step();
      int g;
      m_ack0 = 0;
      m_ack1 = 0;
      m_done = 0;
      if (m_in_fill) begin
         if (m_left > 0) begin
            m_we = 1; m_addr = AW'(m_pos); m_di = m_fv;
            m_pos++; m_left--;
         end else begin
            m_we = 0; m_done = 1; m_busy = 0; m_in_fill = 0;
         end
      end else if (fill_start) begin
         m_in_fill = 1; m_busy = 1; m_fv = fill_val;
         m_we = 1; m_addr = 0; m_di = fill_val;
         m_pos = 1; m_left = NREG - 1;
      end else begin
         g = -1;
         if (req0 && req1) g = 1 - m_last;
         else if (req0) g = 0;
         else if (req1) g = 1;
         if (g == 0) begin
            m_we = 1; m_addr = addr0; m_di = data0; m_ack0 = 1; m_last = 0;
         end else if (g == 1) begin
            m_we = 1; m_addr = addr1; m_di = data1; m_ack1 = 1; m_last = 1;
         end else begin
            m_we = 0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".WE"}, DW'(WE), DW'(m_we));
      chk({tag, ".Addr_W"}, DW'(Addr_W), DW'(m_addr));
      chk({tag, ".Di"}, Di, m_di);
      chk({tag, ".ack0"}, DW'(ack0), DW'(m_ack0));
      chk({tag, ".ack1"}, DW'(ack1), DW'(m_ack1));
      chk({tag, ".busy"}, DW'(fill_busy), DW'(m_busy));
      chk({tag, ".done"}, DW'(fill_done), DW'(m_done));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      chk_model(tag);
   endtask

   typedef struct {
      logic          r0, r1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic          e_ack0, e_ack1, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_di;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{1,0,3,5,32'hAAAAAAA3,32'h55555555, 1,0,1,3,32'hAAAAAAA3};
      vt[1] = '{0,0,3,5,32'hAAAAAAA3,32'h55555555, 0,0,0,3,32'hAAAAAAA3};
      vt[2] = '{1,1,3,5,32'hAAAAAAA3,32'h55555555, 0,1,1,5,32'h55555555};
      vt[3] = '{1,1,3,5,32'hAAAAAAA3,32'h55555555, 1,0,1,3,32'hAAAAAAA3};
      vt[4] = '{1,1,3,5,32'hAAAAAAA3,32'h55555555, 0,1,1,5,32'h55555555};
      vt[5] = '{0,1,3,6,32'hAAAAAAA3,32'h66666666, 0,1,1,6,32'h66666666};
      vt[6] = '{1,1,2,5,32'h22222222,32'h55555555, 1,0,1,2,32'h22222222};
      vt[7] = '{0,0,2,5,32'h22222222,32'h55555555, 0,0,0,2,32'h22222222};

      model_reset();
      #100;
      cr = 1'b0;
      #2;
      chk("rst.WE", DW'(WE), 0);
      chk("rst.Addr_W", DW'(Addr_W), 0);
      chk("rst.Di", Di, 0);
      chk("rst.acks", DW'({ack0, ack1}), 0);
      chk("rst.fill", DW'({fill_busy, fill_done}), 0);

      foreach (vt[i]) begin
         @(negedge clk);
         req0 = vt[i].r0; req1 = vt[i].r1;
         addr0 = vt[i].a0; addr1 = vt[i].a1;
         data0 = vt[i].d0; data1 = vt[i].d1;
         tick($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.ack0", i), DW'(ack0), DW'(vt[i].e_ack0));
         chk($sformatf("vec%0d.ack1", i), DW'(ack1), DW'(vt[i].e_ack1));
         chk($sformatf("vec%0d.WE", i), DW'(WE), DW'(vt[i].e_we));
         chk($sformatf("vec%0d.Addr_W", i), DW'(Addr_W), DW'(vt[i].e_addr));
         chk($sformatf("vec%0d.Di", i), Di, vt[i].e_di);
      end
      #10;
      chk("mem3", mem[3], 32'hAAAAAAA3);

      // Fill with a competing request in the start cycle
      @(negedge clk);
      fill_start = 1; fill_val = 32'hDEADBEEF;
      req1 = 1; addr1 = 5; data1 = 32'h55555555;
      for (int i = 0; i < NREG; i++) begin
         tick($sformatf("fill%0d", i));
         fill_start = 0;
         chk($sformatf("fill%0d.WE", i), DW'(WE), 1);
         chk($sformatf("fill%0d.addr", i), DW'(Addr_W), DW'(i));
         chk($sformatf("fill%0d.ack1", i), DW'(ack1), 0);
         chk($sformatf("fill%0d.busy", i), DW'(fill_busy), 1);
      end
      tick("fill_end");
      chk("fill_end.done", DW'(fill_done), 1);
      chk("fill_end.busy", DW'(fill_busy), 0);
      chk("fill_end.ack1", DW'(ack1), 0);
      tick("post_fill");
      chk("post_fill.ack1", DW'(ack1), 1);
      chk("post_fill.addr", DW'(Addr_W), 5);
      req1 = 0;
      tick("post_fill2");
      for (int i = 0; i < NREG; i++)
         chk($sformatf("fillmem%0d", i), mem[i],
             (i == 5) ? 32'h55555555 : 32'hDEADBEEF);

      // Reset in the middle of a fill
      @(negedge clk);
      fill_start = 1; fill_val = 32'h12345678;
      tick("rf0");
      fill_start = 0;
      for (int i = 1; i < 4; i++) tick($sformatf("rf%0d", i));
      cr = 1;
      #1;
      chk("rf.WE", DW'(WE), 0);
      chk("rf.busy", DW'(fill_busy), 0);
      chk("rf.Addr_W", DW'(Addr_W), 0);
      model_reset();
      @(negedge clk);
      cr = 0;
      for (int i = 0; i < 12; i++) begin
         tick($sformatf("rfidle%0d", i));
         chk($sformatf("rfidle%0d.WE", i), DW'(WE), 0);
      end
      for (int i = 0; i < NREG; i++)
         chk($sformatf("rfmem%0d", i), mem[i], 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         req0 = 1'($urandom);
         req1 = 1'($urandom);
         addr0 = AW'($urandom);
         addr1 = AW'($urandom);
         data0 = $urandom;
         data1 = $urandom;
         fill_start = ($urandom_range(0, 19) == 0);
         fill_val = $urandom;
         tick("rnd");
         if (ack0 && ack1) chk("rnd.both_acks", 1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
